// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes, arbiter state encodings and flag bit positions for the
// ALU sharing arbiter.
package alu_arbiter_pkg;

  localparam logic [3:0] ALUOP_PD1 = 4'h0;
  localparam logic [3:0] ALUOP_PD2 = 4'h1;
  localparam logic [3:0] ALUOP_ADD = 4'h2;
  localparam logic [3:0] ALUOP_ADC = 4'h3;
  localparam logic [3:0] ALUOP_SUB = 4'h4;
  localparam logic [3:0] ALUOP_SBC = 4'h5;
  localparam logic [3:0] ALUOP_AND = 4'h6;
  localparam logic [3:0] ALUOP_OR  = 4'h7;
  localparam logic [3:0] ALUOP_XOR = 4'h8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_EXEC = 2'd1;
  localparam logic [1:0] ARB_WB   = 2'd2;

  localparam int unsigned FLAG_Z  = 3;
  localparam int unsigned FLAG_S  = 2;
  localparam int unsigned FLAG_C  = 1;
  localparam int unsigned FLAG_OF = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting index strictly after
// ptr, searching modulo N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IW'((32'(ptr) + off) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        index        = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one negedge-evaluated 8-bit ALU among
// NUM_REQ requesters, with lock support for carry-dependent op chains.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [NUM_REQ-1:0]   i_Lock,
  input  logic [4*NUM_REQ-1:0] i_Op,
  input  logic [8*NUM_REQ-1:0] i_A,
  input  logic [8*NUM_REQ-1:0] i_B,
  output logic [NUM_REQ-1:0]   o_Gnt,
  output logic [NUM_REQ-1:0]   o_Done,
  output logic [7:0]           o_Result,
  output logic [3:0]           o_Flags,
  output logic                 o_Busy,
  output logic [7:0]           o_ALU_Data1,
  output logic [7:0]           o_ALU_Data2,
  output logic [3:0]           o_ALU_Op,
  input  logic [7:0]           i_ALU_Result,
  input  logic                 i_ALU_Z,
  input  logic                 i_ALU_S,
  input  logic                 i_ALU_C,
  input  logic                 i_ALU_OF
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  alu_req_t           cur;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_index;
  logic               pick_any;
  logic               relock;
  logic               accept;
  logic [IW-1:0]      win;
  alu_req_t           win_req;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (i_Req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // A locked owner still requesting at the WB edge bypasses rotation.
  always_comb begin
    relock  = (state == ARB_WB) && i_Lock[owner] && i_Req[owner];
    win     = relock ? owner : pick_index;
    accept  = (state != ARB_EXEC) && (relock || pick_any);
    win_req = '0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (IW'(n) == win) begin
        win_req.op = i_Op[4*n +: 4];
        win_req.a  = i_A[8*n +: 8];
        win_req.b  = i_B[8*n +: 8];
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state    <= ARB_IDLE;
      rr_ptr   <= IW'(NUM_REQ - 1);
      owner    <= '0;
      cur      <= '{op: ALUOP_PD1, a: '0, b: '0};
      o_Gnt    <= '0;
      o_Done   <= '0;
      o_Result <= '0;
      o_Flags  <= '0;
    end else begin
      o_Done <= '0;
      case (state)
        ARB_EXEC: begin
          o_Result         <= i_ALU_Result;
          o_Flags[FLAG_Z]  <= i_ALU_Z;
          o_Flags[FLAG_S]  <= i_ALU_S;
          o_Flags[FLAG_C]  <= i_ALU_C;
          o_Flags[FLAG_OF] <= i_ALU_OF;
          o_Done           <= o_Gnt;
          state            <= ARB_WB;
        end
        default: begin
          if (accept) begin
            cur    <= win_req;
            owner  <= win;
            rr_ptr <= win;
            if (!relock) o_Gnt <= pick_onehot;
            state  <= ARB_EXEC;
          end else begin
            o_Gnt <= '0;
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Outside EXEC the ALU sees a pass-through that leaves its flags intact.
  always_comb begin
    o_ALU_Op    = ALUOP_PD1;
    o_ALU_Data1 = '0;
    o_ALU_Data2 = '0;
    if (state == ARB_EXEC) begin
      o_ALU_Op    = cur.op;
      o_ALU_Data1 = cur.a;
      o_ALU_Data2 = cur.b;
    end
  end

  assign o_Busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (2 and 3 requesters), each with a
// stand-in negedge ALU, checked every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NI = 2;
  int nreq [NI] = '{2, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0] req  [NI];
  logic [3:0] lock [NI];
  logic [3:0] op   [NI][4];
  logic [7:0] opa  [NI][4];
  logic [7:0] opb  [NI][4];

  logic [7:0] alu_res [NI];
  logic [3:0] alu_flg [NI];

  logic [1:0] g0, dn0;
  logic [2:0] g1, dn1;
  logic [7:0] r0, r1, d10, d11, d20, d21;
  logic [3:0] f0, f1, bo0, bo1;
  logic       bz0, bz1;

  logic [3:0] d_gnt [NI], d_done [NI], d_flg [NI], bus_op [NI];
  logic [7:0] d_res [NI], bus_d1 [NI], bus_d2 [NI];
  logic       d_busy [NI];

  always_comb begin
    d_gnt[0] = {2'b00, g0};  d_gnt[1] = {1'b0, g1};
    d_done[0] = {2'b00, dn0}; d_done[1] = {1'b0, dn1};
    d_res[0] = r0;  d_res[1] = r1;
    d_flg[0] = f0;  d_flg[1] = f1;
    d_busy[0] = bz0; d_busy[1] = bz1;
    bus_op[0] = bo0; bus_op[1] = bo1;
    bus_d1[0] = d10; bus_d1[1] = d11;
    bus_d2[0] = d20; bus_d2[1] = d21;
  end

  alu_arbiter #(.NUM_REQ(2)) dut2 (
    .i_CLK(clk), .i_RST(rst_n),
    .i_Req(req[0][1:0]), .i_Lock(lock[0][1:0]),
    .i_Op({op[0][1], op[0][0]}),
    .i_A({opa[0][1], opa[0][0]}),
    .i_B({opb[0][1], opb[0][0]}),
    .o_Gnt(g0), .o_Done(dn0), .o_Result(r0), .o_Flags(f0), .o_Busy(bz0),
    .o_ALU_Data1(d10), .o_ALU_Data2(d20), .o_ALU_Op(bo0),
    .i_ALU_Result(alu_res[0]),
    .i_ALU_Z(alu_flg[0][3]), .i_ALU_S(alu_flg[0][2]),
    .i_ALU_C(alu_flg[0][1]), .i_ALU_OF(alu_flg[0][0])
  );

  alu_arbiter #(.NUM_REQ(3)) dut3 (
    .i_CLK(clk), .i_RST(rst_n),
    .i_Req(req[1][2:0]), .i_Lock(lock[1][2:0]),
    .i_Op({op[1][2], op[1][1], op[1][0]}),
    .i_A({opa[1][2], opa[1][1], opa[1][0]}),
    .i_B({opb[1][2], opb[1][1], opb[1][0]}),
    .o_Gnt(g1), .o_Done(dn1), .o_Result(r1), .o_Flags(f1), .o_Busy(bz1),
    .o_ALU_Data1(d11), .o_ALU_Data2(d21), .o_ALU_Op(bo1),
    .i_ALU_Result(alu_res[1]),
    .i_ALU_Z(alu_flg[1][3]), .i_ALU_S(alu_flg[1][2]),
    .i_ALU_C(alu_flg[1][1]), .i_ALU_OF(alu_flg[1][0])
  );

  // ALU behaviour from first principles: returns {result, Z, S, C, OF}.
  function automatic logic [11:0] alu_eval(input logic [3:0] f, input logic [7:0] x,
                                           input logic [7:0] y, input logic [3:0] fl);
    int ux, uy, sx, sy, u, s, cin;
    logic [7:0] r;
    logic c, v;
    bit arith;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    cin = int'(fl[1]);
    u = 0; s = 0; arith = 1'b1;
    case (f)
      ALUOP_ADD: begin u = ux + uy;       s = sx + sy;       end
      ALUOP_ADC: begin u = ux + uy + cin; s = sx + sy + cin; end
      ALUOP_SUB: begin u = ux - uy;       s = sx - sy;       end
      ALUOP_SBC: begin u = ux - uy - cin; s = sx - sy - cin; end
      default:   arith = 1'b0;
    endcase
    if (arith) begin
      r = 8'(u);
      c = (u > 255) || (u < 0);
      v = (s > 127) || (s < -128);
      return {r, r == 8'h00, r[7], c, v};
    end
    case (f)
      ALUOP_AND: begin r = x & y; return {r, r == 8'h00, r[7], 2'b00}; end
      ALUOP_OR:  begin r = x | y; return {r, r == 8'h00, r[7], 2'b00}; end
      ALUOP_XOR: begin r = x ^ y; return {r, r == 8'h00, r[7], 2'b00}; end
      ALUOP_PD1: return {x, fl};
      ALUOP_PD2: return {y, fl};
      default:   return {8'h00, fl};
    endcase
  endfunction

  always @(negedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        alu_res[i] <= 8'h00;
        alu_flg[i] <= 4'h0;
      end else begin
        {alu_res[i], alu_flg[i]} <= alu_eval(bus_op[i], bus_d1[i], bus_d2[i], alu_flg[i]);
      end
    end
  end

  // Transaction-level model: phase 0 idle, 1 op in flight, 2 result returned.
  int         m_phase [NI], m_owner [NI], m_ptr [NI];
  logic [3:0] m_op [NI], m_flg [NI], m_aluflg [NI];
  logic [7:0] m_a [NI], m_b [NI], m_res [NI];
  bit         m_done [NI], m_acc [NI];
  logic [3:0] glog0 [$];
  logic [3:0] glog1 [$];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_phase[i] = 0; m_owner[i] = 0; m_ptr[i] = nreq[i] - 1;
      m_op[i] = ALUOP_PD1; m_a[i] = 8'h00; m_b[i] = 8'h00;
      m_res[i] = 8'h00; m_flg[i] = 4'h0; m_aluflg[i] = 4'h0;
      m_done[i] = 1'b0; m_acc[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    int w;
    logic [11:0] rf;
    m_acc[i] = 1'b0;
    if (m_phase[i] == 1) begin
      rf = alu_eval(m_op[i], m_a[i], m_b[i], m_aluflg[i]);
      m_res[i] = rf[11:4];
      m_flg[i] = rf[3:0];
      m_aluflg[i] = rf[3:0];
      m_done[i] = 1'b1;
      m_phase[i] = 2;
    end else begin
      m_done[i] = 1'b0;
      w = -1;
      if (m_phase[i] == 2 && lock[i][m_owner[i]] && req[i][m_owner[i]]) begin
        w = m_owner[i];
      end else begin
        for (int k = 1; k <= nreq[i]; k++) begin
          if (w < 0 && req[i][(m_ptr[i] + k) % nreq[i]]) w = (m_ptr[i] + k) % nreq[i];
        end
      end
      if (w >= 0) begin
        m_owner[i] = w; m_ptr[i] = w;
        m_op[i] = op[i][w]; m_a[i] = opa[i][w]; m_b[i] = opb[i][w];
        m_phase[i] = 1; m_acc[i] = 1'b1;
      end else begin
        m_phase[i] = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("gnt[%0d]", i), 32'(d_gnt[i]),
          (m_phase[i] != 0) ? 32'(1 << m_owner[i]) : 32'h0);
      chk($sformatf("done[%0d]", i), 32'(d_done[i]),
          m_done[i] ? 32'(1 << m_owner[i]) : 32'h0);
      chk($sformatf("result[%0d]", i), 32'(d_res[i]), 32'(m_res[i]));
      chk($sformatf("flags[%0d]", i), 32'(d_flg[i]), 32'(m_flg[i]));
      chk($sformatf("busy[%0d]", i), 32'(d_busy[i]), 32'(m_phase[i] != 0));
      chk($sformatf("aluop[%0d]", i), 32'(bus_op[i]), (m_phase[i] == 1) ? 32'(m_op[i]) : 32'(ALUOP_PD1));
      chk($sformatf("alud1[%0d]", i), 32'(bus_d1[i]), (m_phase[i] == 1) ? 32'(m_a[i]) : 32'h0);
      chk($sformatf("alud2[%0d]", i), 32'(bus_d2[i]), (m_phase[i] == 1) ? 32'(m_b[i]) : 32'h0);
      if (m_acc[i]) begin
        if (i == 0) glog0.push_back(d_gnt[i]);
        else        glog1.push_back(d_gnt[i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input int r, input logic [3:0] f,
                        input logic [7:0] x, input logic [7:0] y);
    op[i][r] = f; opa[i][r] = x; opb[i][r] = y;
  endtask

  function automatic logic [3:0] qget(input int i, input int k);
    if (i == 0) return (k < glog0.size()) ? glog0[k] : 4'hx;
    return (k < glog1.size()) ? glog1[k] : 4'hx;
  endfunction

  logic [3:0] exp_ord0 [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] exp_ord1 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req[i] = 4'h0; lock[i] = 4'h0;
      for (int r = 0; r < 4; r++) set_op(i, r, ALUOP_PD1, 8'h00, 8'h00);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(d_gnt[0]), 32'h0);
    chk("rst_busy", 32'(d_busy[0]), 32'h0);
    chk("rst_aluop", 32'(bus_op[0]), 32'(ALUOP_PD1));
    rst_n = 1'b1;

    // Full contention from reset: strict rotation.
    set_op(0, 0, ALUOP_ADD, 8'h01, 8'h02);
    set_op(0, 1, ALUOP_SUB, 8'h09, 8'h03);
    set_op(1, 0, ALUOP_XOR, 8'h5A, 8'hFF);
    set_op(1, 2, ALUOP_ADD, 8'h10, 8'h20);
    req[0] = 4'b0011; req[1] = 4'b0101;
    glog0.delete(); glog1.delete();
    tick(8);
    req[0] = 4'h0; req[1] = 4'h0;
    tick(1);
    chk("order2_count", 32'(glog0.size()), 32'd4);
    chk("order3_count", 32'(glog1.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order2_%0d", k), 32'(qget(0, k)), 32'(exp_ord0[k]));
      chk($sformatf("order3_%0d", k), 32'(qget(1, k)), 32'(exp_ord1[k]));
    end

    // Single requester ADD 0x7F+0x01.
    set_op(0, 0, ALUOP_ADD, 8'h7F, 8'h01);
    req[0] = 4'b0001;
    tick(1);
    chk("add_gnt", 32'(d_gnt[0]), 32'h1);
    chk("add_nodone", 32'(d_done[0]), 32'h0);
    req[0] = 4'h0;
    tick(1);
    chk("add_done", 32'(d_done[0]), 32'h1);
    chk("add_res", 32'(d_res[0]), 32'h80);
    chk("add_flg", 32'(d_flg[0]), 32'b0101);
    tick(1);
    chk("add_idle", 32'(d_busy[0]), 32'h0);

    // Locked ADD/ADC chain on requester 1 while requester 0 waits.
    set_op(0, 0, ALUOP_AND, 8'hF0, 8'h3C);
    set_op(0, 1, ALUOP_ADD, 8'hFF, 8'h01);
    req[0] = 4'b0011; lock[0] = 4'b0010;
    tick(1);
    chk("lock_gnt1", 32'(d_gnt[0]), 32'h2);
    set_op(0, 1, ALUOP_ADC, 8'h00, 8'h00);
    tick(1);
    chk("lock_res1", 32'(d_res[0]), 32'h00);
    chk("lock_flg1", 32'(d_flg[0]), 32'b1010);
    tick(1);
    chk("lock_gnt2", 32'(d_gnt[0]), 32'h2);
    req[0] = 4'b0001; lock[0] = 4'h0;
    tick(1);
    chk("lock_res2", 32'(d_res[0]), 32'h01);
    chk("lock_done2", 32'(d_done[0]), 32'h2);
    tick(1);
    chk("lock_gnt0", 32'(d_gnt[0]), 32'h1);
    req[0] = 4'h0;
    tick(2);

    // Carry survives an idle stretch.
    set_op(0, 0, ALUOP_SUB, 8'h00, 8'h01);
    req[0] = 4'b0001;
    tick(1);
    req[0] = 4'h0;
    tick(1);
    chk("sub_res", 32'(d_res[0]), 32'hFF);
    chk("sub_flg", 32'(d_flg[0]), 32'b0110);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("idle_op", 32'(bus_op[0]), 32'(ALUOP_PD1));
      chk("idle_busy", 32'(d_busy[0]), 32'h0);
      chk("idle_flg", 32'(d_flg[0]), 32'b0110);
    end
    set_op(0, 0, ALUOP_ADC, 8'h00, 8'h00);
    req[0] = 4'b0001;
    tick(1);
    req[0] = 4'h0;
    tick(1);
    chk("adc_keepc", 32'(d_res[0]), 32'h01);
    tick(1);

    // Reset during EXEC abandons the op.
    set_op(0, 0, ALUOP_ADD, 8'h11, 8'h22);
    req[0] = 4'b0001;
    tick(1);
    req[0] = 4'h0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_gnt", 32'(d_gnt[0]), 32'h0);
    chk("mid_rst_done", 32'(d_done[0]), 32'h0);
    chk("mid_rst_res", 32'(d_res[0]), 32'h00);
    chk("mid_rst_flg", 32'(d_flg[0]), 32'h0);
    chk("mid_rst_busy", 32'(d_busy[0]), 32'h0);
    chk("mid_rst_aluop", 32'(bus_op[0]), 32'(ALUOP_PD1));
    chk("mid_rst_d1", 32'(bus_d1[0]), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_nodone", 32'(d_done[0]), 32'h0);
    set_op(0, 0, ALUOP_ADD, 8'h01, 8'h02);
    req[0] = 4'b0001;
    tick(1);
    req[0] = 4'h0;
    tick(1);
    chk("post_rst_done", 32'(d_done[0]), 32'h1);
    chk("post_rst_res", 32'(d_res[0]), 32'h03);
    tick(1);

    // Randomized traffic on both instances.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NI; i++) begin
        req[i]  = 4'($urandom) & 4'((1 << nreq[i]) - 1);
        lock[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        for (int r = 0; r < 4; r++)
          set_op(i, r, 4'($urandom_range(0, 9)), 8'($urandom), 8'($urandom));
      end
      tick(1);
    end
    for (int i = 0; i < NI; i++) begin
      req[i] = 4'h0; lock[i] = 4'h0;
    end
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit ALU among up to four requesters, such as the instruction decoder and an address/DMA engine. It accepts one operation at a time, drives the ALU operand/opcode bus, captures the result and flags after the ALU's negedge evaluation, and returns them to the winner with a one-cycle done pulse. A lock input lets a requester keep the ALU, and therefore its carry flag, across dependent operations such as ADD followed by ADC.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- i_CLK  in  1  clock; controller acts on posedge, ALU on negedge
- i_RST  in  1  reset, asynchronous, active-low
- i_Req  in  NUM_REQ  per-requester request level
- i_Lock  in  NUM_REQ  keep ownership after the current op
- i_Op  in  4*NUM_REQ  ALUOP code, requester n at [4n+3:4n]
- i_A  in  8*NUM_REQ  operand 1, requester n at [8n+7:8n]
- i_B  in  8*NUM_REQ  operand 2, same packing
- o_Gnt  out  NUM_REQ  one-hot owner, high in EXEC and WB
- o_Done  out  NUM_REQ  one-cycle pulse, result valid
- o_Result  out  8  captured ALU result
- o_Flags  out  4  captured {Z,S,C,OF}
- o_Busy  out  1  state != IDLE
- o_ALU_Data1, o_ALU_Data2  out  8  to ALU i_Data1/i_Data2
- o_ALU_Op  out  4  to ALU i_ALUOp
- i_ALU_Result  in  8;  i_ALU_Z, i_ALU_S, i_ALU_C, i_ALU_OF  in  1 each  from ALU

## Operation
- States: IDLE, EXEC, WB.
- Acceptance at a posedge in IDLE or WB:
  - If the owner has i_Lock and i_Req high (WB only), the owner is re-accepted.
  - Otherwise the winner is the first requesting index after rr_ptr, searching modulo NUM_REQ.
  - On accept: latch the winner's op and operands, set o_Gnt=onehot(w), set rr_ptr=w, go to EXEC.
  - With no request, go to or stay in IDLE with o_Gnt=0.
- EXEC: the ALU bus carries the latched op and operands. At the next posedge, capture i_ALU_Result and the flags into o_Result/o_Flags, pulse o_Done[w], and go to WB.
- WB: o_Done[w] is high for this cycle only. An i_Req level sampled at the WB-exit edge is a new request. A requester that wants no further op drops i_Req during WB.
- Lock without a request at the WB edge releases ownership.
- Outside EXEC, the ALU bus carries ALUOP_PD1 with both data at 0x00. The ALU result register changes, but its flags are preserved.
- Opcodes are passed through unchecked.
- o_Result/o_Flags hold until the next capture.

## Timing
- Reset (async, i_RST=0) values:
  - state=IDLE
  - o_Gnt=0, o_Done=0, o_Result=0x00, o_Flags=0
  - o_Busy=0
  - ALU bus = PD1/0x00/0x00
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
- Latency:
  - Accept at edge k.
  - ALU evaluates at negedge k+½.
  - Capture and o_Done at edge k+1.
  - Next accept earliest at k+2, giving back-to-back throughput of 1 op per 2 cycles.
- Reset asserted in EXEC or WB: the op is abandoned and no o_Done is issued. The ALU shares i_RST, so its flags clear too.
- Simultaneous requests: rotation order is strict. Under full contention with NUM_REQ=2 the grants alternate 0,1,0,1.
- Lock cannot starve others indefinitely only through requester discipline; the arbiter does not time out.
- i_Op/i_A/i_B are sampled only at the accept edge; later changes are ignored.

## Structure
- Constants.v (shared): the ALUOP codes already used by the ALU, plus new state encodings (ARB_IDLE, ARB_EXEC, ARB_WB) and flag bit indices (FLAG_Z=3, FLAG_S=2, FLAG_C=1, FLAG_OF=0).
- Sub-module rr_pick: combinational round-robin selector with inputs req and ptr, outputs onehot, index and any. It is instantiated once.

## Test plan
- Single requester 0, ADD 0x7F+0x01:
  - Done exactly 1 cycle after accept.
  - o_Result=0x80, o_Flags=0b0101 (S=1, OF=1).
- Requesters 0 and 1 both high from reset with continuous requests: grants 0,1,0,1, and every o_Done lines up with its o_Gnt.
- Locked sequence:
  - Requester 1 issues ADD 0xFF+0x01, giving 0x00, Z=1, C=1, then ADC with A=0x00 and lock held, giving 0x01.
  - Requester 0, requesting throughout, is not granted until lock drops.
- Idle for 10 cycles after SUB 0x00-0x01 (C=1):
  - ALU op=PD1 and o_Busy=0.
  - o_Flags stays {0,1,1,0}, and the ALU C flag is still 1 at the next op.
- Reset pulsed during EXEC: no o_Done, all outputs at reset values, and the next request completes normally.
- NUM_REQ=3 with requests on 0 and 2 held high: grant order 0,2,0,2, and index 1 is never granted.
